// File: rtl/pe_driver.sv
// pe_driver: sequences one PE through a convolution job.
// Streams K*K weights and A*A activations from the GLB into the
// PE load port, then issues A-K+1 compute starts and returns each
// partial sum with its row index.
// Ports:
//   clk, reset (async, active-low)
//   cmd_start / busy / done        : command side handshake
//   glb_rd_en/addr, glb_rd_data    : GLB read port (1-cycle latency)
//   filt_out, act_out, load_en_*   : PE load port
//   pe_start, pe_load_done, pe_compute_done, pe_psum : PE control
//   psum_valid, psum_data, psum_idx : partial-sum output stream
module pe_driver #(
    parameter int DATA_BITWIDTH     = 16,
    parameter int GLB_ADDR_BITWIDTH = 10,
    parameter int KERNEL_SIZE       = 3,
    parameter int ACT_SIZE          = 5,
    parameter int W_BASE            = 0,
    parameter int A_BASE            = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_start,
    output logic                         busy,
    output logic                         done,
    output logic                         glb_rd_en,
    output logic [GLB_ADDR_BITWIDTH-1:0] glb_rd_addr,
    input  logic [DATA_BITWIDTH-1:0]     glb_rd_data,
    output logic [DATA_BITWIDTH-1:0]     filt_out,
    output logic [DATA_BITWIDTH-1:0]     act_out,
    output logic                         load_en_wght,
    output logic                         load_en_act,
    output logic                         pe_start,
    input  logic                         pe_load_done,
    input  logic                         pe_compute_done,
    input  logic [DATA_BITWIDTH-1:0]     pe_psum,
    output logic                         psum_valid,
    output logic [DATA_BITWIDTH-1:0]     psum_data,
    output logic [2:0]                   psum_idx
);

    localparam int NW = KERNEL_SIZE * KERNEL_SIZE;
    localparam int NA = ACT_SIZE * ACT_SIZE;
    localparam int CW_MIN = $clog2(NA + 1);
    localparam int CW = (CW_MIN > 10) ? CW_MIN : 10;
    localparam int AW = GLB_ADDR_BITWIDTH;

    localparam logic [CW-1:0] W_WORDS  = CW'(NW);
    localparam logic [CW-1:0] A_WORDS  = CW'(NA);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] LAST_ROW = CW'(ACT_SIZE - KERNEL_SIZE);
    localparam logic [AW-1:0] W_BASE_A = AW'(W_BASE);
    localparam logic [AW-1:0] A_BASE_A = AW'(A_BASE);

    typedef enum logic [3:0] {
        IDLE, RD_W, WAIT_WL, RD_A, WAIT_AL,
        START, WAIT_C, GAP, FIN
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [CW-1:0]            row_q, row_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     rd_en_q, rd_en_d;
    logic [AW-1:0]            rd_addr_q, rd_addr_d;
    logic                     ld_w_q, ld_w_d;
    logic                     ld_a_q, ld_a_d;
    logic                     wvld_q, wvld_d;
    logic                     avld_q, avld_d;
    logic                     start_q, start_d;
    logic                     pv_q, pv_d;
    logic [DATA_BITWIDTH-1:0] pdata_q, pdata_d;
    logic [2:0]               pidx_q, pidx_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
        ld_w_d    = 1'b0;
        ld_a_d    = 1'b0;
        // GLB data lags the read by one cycle, so the data window is
        // the burst state delayed by one register.
        wvld_d    = (state_q == RD_W);
        avld_d    = (state_q == RD_A);
        start_d   = 1'b0;
        pv_d      = 1'b0;
        pdata_d   = pdata_q;
        pidx_d    = pidx_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    state_d   = RD_W;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = W_BASE_A;
                    cnt_d     = CNT_ONE;
                end
            end
            RD_W: begin
                // cnt_q == 1 on the first burst cycle: word 0 lands next
                ld_w_d = (cnt_q == CNT_ONE);
                if (cnt_q < W_WORDS) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = W_BASE_A + AW'(cnt_q);
                    cnt_d     = cnt_q + CNT_ONE;
                end else begin
                    state_d = WAIT_WL;
                end
            end
            WAIT_WL: begin
                if (pe_load_done) begin
                    state_d   = RD_A;
                    rd_en_d   = 1'b1;
                    rd_addr_d = A_BASE_A;
                    cnt_d     = CNT_ONE;
                end
            end
            RD_A: begin
                ld_a_d = (cnt_q == CNT_ONE);
                if (cnt_q < A_WORDS) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = A_BASE_A + AW'(cnt_q);
                    cnt_d     = cnt_q + CNT_ONE;
                end else begin
                    state_d = WAIT_AL;
                end
            end
            WAIT_AL: begin
                if (pe_load_done) begin
                    row_d   = '0;
                    state_d = START;
                    start_d = 1'b1;
                end
            end
            START: begin
                state_d = WAIT_C;
            end
            WAIT_C: begin
                if (pe_compute_done) begin
                    pdata_d = pe_psum;
                    pidx_d  = row_q[2:0];
                    pv_d    = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                // PE keeps compute_done high until it is idle again
                if (!pe_compute_done) begin
                    if (row_q == LAST_ROW) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        row_d   = row_q + CNT_ONE;
                        state_d = START;
                        start_d = 1'b1;
                    end
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            row_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            ld_w_q    <= 1'b0;
            ld_a_q    <= 1'b0;
            wvld_q    <= 1'b0;
            avld_q    <= 1'b0;
            start_q   <= 1'b0;
            pv_q      <= 1'b0;
            pdata_q   <= '0;
            pidx_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            ld_w_q    <= ld_w_d;
            ld_a_q    <= ld_a_d;
            wvld_q    <= wvld_d;
            avld_q    <= avld_d;
            start_q   <= start_d;
            pv_q      <= pv_d;
            pdata_q   <= pdata_d;
            pidx_q    <= pidx_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign glb_rd_en    = rd_en_q;
    assign glb_rd_addr  = rd_addr_q;
    assign filt_out     = wvld_q ? glb_rd_data : '0;
    assign act_out      = avld_q ? glb_rd_data : '0;
    assign load_en_wght = ld_w_q;
    assign load_en_act  = ld_a_q;
    assign pe_start     = start_q;
    assign psum_valid   = pv_q;
    assign psum_data    = pdata_q;
    assign psum_idx     = pidx_q;

endmodule

// File: tb/tb_pe_driver.sv
// tb_pe_driver: randomized scoreboard bench for pe_driver with a
// behavioural GLB and PE model.
module tb_pe_driver;

    localparam int DW = 16;
    localparam int AWID = 10;
    localparam int K = 3;
    localparam int A = 5;
    localparam int WB = 0;
    localparam int AB = 16;
    localparam int NW = K * K;
    localparam int NA = A * A;
    localparam int NR = A - K + 1;

    logic            clk;
    logic            reset;
    logic            cmd_start;
    logic            busy;
    logic            done;
    logic            glb_rd_en;
    logic [AWID-1:0] glb_rd_addr;
    logic [DW-1:0]   glb_rd_data;
    logic [DW-1:0]   filt_out;
    logic [DW-1:0]   act_out;
    logic            load_en_wght;
    logic            load_en_act;
    logic            pe_start;
    logic            pe_load_done;
    logic            pe_compute_done;
    logic [DW-1:0]   pe_psum;
    logic            psum_valid;
    logic [DW-1:0]   psum_data;
    logic [2:0]      psum_idx;

    pe_driver #(
        .DATA_BITWIDTH(DW),
        .GLB_ADDR_BITWIDTH(AWID),
        .KERNEL_SIZE(K),
        .ACT_SIZE(A),
        .W_BASE(WB),
        .A_BASE(AB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_start(cmd_start),
        .busy(busy),
        .done(done),
        .glb_rd_en(glb_rd_en),
        .glb_rd_addr(glb_rd_addr),
        .glb_rd_data(glb_rd_data),
        .filt_out(filt_out),
        .act_out(act_out),
        .load_en_wght(load_en_wght),
        .load_en_act(load_en_act),
        .pe_start(pe_start),
        .pe_load_done(pe_load_done),
        .pe_compute_done(pe_compute_done),
        .pe_psum(pe_psum),
        .psum_valid(psum_valid),
        .psum_data(psum_data),
        .psum_idx(psum_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int done_cnt = 0;
    int hold_cfg = 0;

    logic [DW-1:0]   mem [1024];
    logic [AWID-1:0] exp_addr_q [$];
    logic [2:0]      exp_idx_q [$];
    logic [DW-1:0]   exp_data_q [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // GLB: registered read, garbage when not reading
    always @(posedge clk)
        glb_rd_data <= glb_rd_en ? mem[glb_rd_addr] : DW'($urandom);

    // PE model
    logic [DW-1:0] wbuf [NW];
    logic [DW-1:0] abuf [NA];
    int  wi, ai, ld_cd, c_cd, c_hold, starts, row;
    bit  w_act, a_act;

    function automatic logic [DW-1:0] pe_calc(int r);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                s += 32'(wbuf[i*K+j]) * 32'(abuf[(r+i)*A+j]);
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] ref_psum(int r);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                s += 32'(mem[WB+i*K+j]) * 32'(mem[AB+(r+i)*A+j]);
        return s[DW-1:0];
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            w_act = 0; a_act = 0;
            ld_cd = 0; c_cd = 0; c_hold = 0; starts = 0;
            pe_load_done = 1'b0;
            pe_compute_done = 1'b0;
            pe_psum = '0;
        end else begin
            pe_load_done = 1'b0;
            if (load_en_wght) begin
                chk("lew_single", 32'(w_act), 0);
                w_act = 1; wi = 0; starts = 0;
            end
            if (w_act) begin
                chk("filt_out", filt_out, mem[WB+wi]);
                wbuf[wi] = filt_out;
                wi++;
                if (wi == NW) begin
                    w_act = 0;
                    ld_cd = $urandom_range(1, 3);
                end
            end else begin
                chk("filt_idle", filt_out, 0);
            end
            if (load_en_act) begin
                chk("lea_single", 32'(a_act), 0);
                a_act = 1; ai = 0;
            end
            if (a_act) begin
                chk("act_out", act_out, mem[AB+ai]);
                abuf[ai] = act_out;
                ai++;
                if (ai == NA) begin
                    a_act = 0;
                    ld_cd = $urandom_range(1, 3);
                end
            end else begin
                chk("act_idle", act_out, 0);
            end
            if (ld_cd > 0) begin
                ld_cd--;
                if (ld_cd == 0) pe_load_done = 1'b1;
            end else if (c_cd > 0 && $urandom_range(0, 3) == 0) begin
                pe_load_done = 1'b1;
            end
            if (pe_start) begin
                chk("start_cdone_low", 32'(pe_compute_done), 0);
                row = starts;
                starts++;
                c_cd = $urandom_range(1, 4);
            end else if (c_hold > 0) begin
                c_hold--;
                if (c_hold == 0) begin
                    pe_compute_done = 1'b0;
                    pe_psum = DW'($urandom);
                end
            end else if (c_cd > 0) begin
                c_cd--;
                if (c_cd == 0) begin
                    pe_compute_done = 1'b1;
                    pe_psum = pe_calc(row);
                    c_hold = (hold_cfg > 0) ? hold_cfg
                                            : $urandom_range(1, 2);
                end
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset) begin
            if (glb_rd_en) begin
                if (exp_addr_q.size() == 0)
                    chk("rd_extra", 32'(glb_rd_en), 0);
                else
                    chk("rd_addr", 32'(glb_rd_addr),
                        32'(exp_addr_q.pop_front()));
            end
            if (psum_valid) begin
                if (exp_idx_q.size() == 0) begin
                    chk("psum_extra", 32'(psum_valid), 0);
                end else begin
                    chk("psum_idx", 32'(psum_idx),
                        32'(exp_idx_q.pop_front()));
                    chk("psum_data", 32'(psum_data),
                        32'(exp_data_q.pop_front()));
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic load_mem(input int mode);
        for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
        if (mode == 0) begin
            for (int i = 0; i < NW; i++) mem[WB+i] = DW'(i + 1);
            for (int i = 0; i < NA; i++) mem[AB+i] = DW'(i + 1);
        end else if (mode == 1) begin
            for (int i = 0; i < NW; i++) mem[WB+i] = DW'(1);
            for (int i = 0; i < NA; i++) mem[AB+i] = DW'(i + 1);
        end
    endtask

    task automatic push_job();
        for (int i = 0; i < NW; i++) exp_addr_q.push_back(AWID'(WB + i));
        for (int i = 0; i < NA; i++) exp_addr_q.push_back(AWID'(AB + i));
        for (int r = 0; r < NR; r++) begin
            exp_idx_q.push_back(3'(r));
            exp_data_q.push_back(ref_psum(r));
        end
    endtask

    task automatic flush();
        exp_addr_q.delete();
        exp_idx_q.delete();
        exp_data_q.delete();
    endtask

    task automatic run_job(input int hold, input bit inject,
                           input bit first);
        int  d0, cyc;
        bit  armed, fired;
        push_job();
        d0 = done_cnt;
        hold_cfg = hold;
        @(negedge clk);
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        if (first) begin
            chk("busy_t1", 32'(busy), 1);
            chk("rd_en_t1", 32'(glb_rd_en), 1);
            chk("lew_t1", 32'(load_en_wght), 0);
            @(negedge clk);
            chk("lew_t2", 32'(load_en_wght), 1);
        end
        armed = 0; fired = 0; cyc = 0;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            cmd_start = 1'b0;
            if (inject && !fired) begin
                if (armed) begin
                    cmd_start = 1'b1;
                    fired = 1;
                end else if (pe_start) begin
                    armed = 1;
                end
            end
        end
        chk("done_seen", 32'(done), 1);
        chk("busy_at_done", 32'(busy), 1);
        @(negedge clk);
        cmd_start = 1'b0;
        chk("busy_after_done", 32'(busy), 0);
        repeat (12) @(negedge clk);
        chk("done_count", 32'(done_cnt - d0), 1);
        chk("psum_q_empty", 32'(exp_idx_q.size()), 0);
        chk("addr_q_empty", 32'(exp_addr_q.size()), 0);
        if (cyc >= 4000) begin
            reset = 1'b0;
            flush();
            repeat (2) @(negedge clk);
            reset = 1'b1;
        end
    endtask

    task automatic abort_job();
        int d0, cyc;
        push_job();
        d0 = done_cnt;
        hold_cfg = 0;
        @(negedge clk);
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        cyc = 0;
        while (!load_en_act && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_rd_a", 32'(load_en_act), 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rd_en", 32'(glb_rd_en), 0);
        chk("rst_rd_addr", 32'(glb_rd_addr), 0);
        chk("rst_act_out", 32'(act_out), 0);
        chk("rst_filt_out", 32'(filt_out), 0);
        chk("rst_lea", 32'(load_en_act), 0);
        chk("rst_psum_data", 32'(psum_data), 0);
        chk("rst_psum_idx", 32'(psum_idx), 0);
        flush();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 0);
        chk("abort_idle", 32'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        cmd_start = 1'b0;
        load_mem(2);
        repeat (3) @(negedge clk);
        chk("init_busy", 32'(busy), 0);
        chk("init_done", 32'(done), 0);
        chk("init_rd_en", 32'(glb_rd_en), 0);
        chk("init_rd_addr", 32'(glb_rd_addr), 0);
        chk("init_pe_start", 32'(pe_start), 0);
        chk("init_ld", 32'({load_en_wght, load_en_act}), 0);
        chk("init_psum", 32'({psum_valid, psum_idx, psum_data}), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        load_mem(0);
        run_job(0, 0, 1);
        load_mem(1);
        run_job(0, 0, 0);
        load_mem(2);
        run_job(5, 0, 0);
        load_mem(2);
        run_job(0, 1, 0);
        load_mem(2);
        abort_job();
        load_mem(0);
        run_job(0, 0, 1);
        for (int j = 0; j < 5; j++) begin
            load_mem(2);
            run_job($urandom_range(0, 4), j[0], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
